// File: rtl/arith_sfr.sv
// ---------------------------------------------------------------------------
// arith_sfr: multi-channel arithmetic SFR bank.
//
// Holds CH independent SIZE-bit accumulators. Each one can be loaded, added to
// or subtracted from (wrap or saturate), with sticky carry/borrow flags. A
// multi-cycle REPSUB command divides a channel in place by repeated
// subtraction: the remainder stays in the channel and the quotient goes to
// o_quot.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset, priority over any command
//   i_cmd_valid  command present
//   o_cmd_ready  command can be accepted this cycle (IDLE and not in reset)
//   i_cmd_op     000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 CLRFLAG, 101 REPSUB
//   i_cmd_ch     target channel
//   i_cmd_data   load value or add/sub/step operand
//   i_sat_en     saturating mode for ADD/SUB, sampled on accept
//   i_rd_ch      read-port channel select
//   o_rd_data    Q[i_rd_ch], combinational, 0 for an out-of-range channel
//   o_zero       per-channel Q==0 flag, combinational
//   o_carry      sticky ADD-overflow flag per channel
//   o_borrow     sticky SUB-underflow flag per channel
//   o_err        sticky error flag
//   o_busy       REPSUB in progress
//   o_done       one-cycle pulse when REPSUB completes
//   o_quot       quotient of the last completed REPSUB
// ---------------------------------------------------------------------------
module arith_sfr #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned CH   = 4,
    parameter int unsigned CHW  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [2:0]      i_cmd_op,
    input  logic [CHW-1:0]  i_cmd_ch,
    input  logic [SIZE-1:0] i_cmd_data,
    input  logic            i_sat_en,
    input  logic [CHW-1:0]  i_rd_ch,
    output logic [SIZE-1:0] o_rd_data,
    output logic [CH-1:0]   o_zero,
    output logic [CH-1:0]   o_carry,
    output logic [CH-1:0]   o_borrow,
    output logic            o_err,
    output logic            o_busy,
    output logic            o_done,
    output logic [SIZE-1:0] o_quot
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REPEAT = 1'b1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_CLRFLAG = 3'b100;
    localparam logic [2:0] OP_REPSUB  = 3'b101;

    // State registers
    logic [0:0]      r_state;
    logic [SIZE-1:0] r_q [CH];
    logic [CH-1:0]   r_carry;
    logic [CH-1:0]   r_borrow;
    logic            r_err;
    logic [SIZE-1:0] r_quot;
    logic            r_zdone;   // done pulse for a zero-step REPSUB
    logic [CHW-1:0]  r_rep_ch;
    logic [SIZE-1:0] r_step;

    // Next-state values
    logic [0:0]      w_state_d;
    logic [SIZE-1:0] w_q_d [CH];
    logic [CH-1:0]   w_carry_d;
    logic [CH-1:0]   w_borrow_d;
    logic            w_err_d;
    logic [SIZE-1:0] w_quot_d;
    logic            w_zdone_d;
    logic [CHW-1:0]  w_rep_ch_d;
    logic [SIZE-1:0] w_step_d;

    // Decode helpers
    logic            w_accept;
    logic [CH-1:0]   w_cmd_sel;
    logic            w_cmd_ch_ok;
    logic            w_op_illegal;
    logic [SIZE-1:0] w_cmd_q;
    logic [SIZE-1:0] w_rep_q;
    logic            w_rep_ge;
    logic [SIZE:0]   w_sum;
    logic [SIZE-1:0] w_diff;
    logic            w_under;

    assign o_cmd_ready  = (r_state == ST_IDLE) & ~i_rst;
    assign w_accept     = i_cmd_valid & o_cmd_ready;
    assign w_op_illegal = (i_cmd_op == 3'b110) | (i_cmd_op == 3'b111);

    // Channel decode by comparison so CHW wider than clog2(CH) stays safe.
    always_comb begin
        w_cmd_sel = '0;
        w_cmd_q   = '0;
        w_rep_q   = '0;
        o_rd_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (i_cmd_ch == CHW'(i)) begin
                w_cmd_sel[i] = 1'b1;
                w_cmd_q      = r_q[i];
            end
            if (r_rep_ch == CHW'(i)) begin
                w_rep_q = r_q[i];
            end
            if (i_rd_ch == CHW'(i)) begin
                o_rd_data = r_q[i];
            end
        end
    end

    assign w_cmd_ch_ok = |w_cmd_sel;
    assign w_rep_ge    = (w_rep_q >= r_step);
    assign w_sum       = {1'b0, w_cmd_q} + {1'b0, i_cmd_data};
    assign w_diff      = w_cmd_q - i_cmd_data;
    assign w_under     = (i_cmd_data > w_cmd_q);

    always_comb begin
        w_state_d  = r_state;
        for (int i = 0; i < CH; i++) begin
            w_q_d[i] = r_q[i];
        end
        w_carry_d  = r_carry;
        w_borrow_d = r_borrow;
        w_err_d    = r_err;
        w_quot_d   = r_quot;
        w_zdone_d  = 1'b0;
        w_rep_ch_d = r_rep_ch;
        w_step_d   = r_step;

        if (r_state == ST_REPEAT) begin
            if (w_rep_ge) begin
                for (int i = 0; i < CH; i++) begin
                    if (r_rep_ch == CHW'(i)) begin
                        w_q_d[i] = w_rep_q - r_step;
                    end
                end
                w_quot_d = r_quot + SIZE'(1);
            end else begin
                w_state_d = ST_IDLE;
            end
        end else if (w_accept) begin
            if (w_op_illegal || ((i_cmd_op != OP_NOP) && !w_cmd_ch_ok)) begin
                w_err_d = 1'b1;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    if (w_cmd_sel[i]) begin
                        case (i_cmd_op)
                            OP_LOAD: begin
                                w_q_d[i] = i_cmd_data;
                            end
                            OP_ADD: begin
                                if (w_sum[SIZE]) begin
                                    w_carry_d[i] = 1'b1;
                                end
                                w_q_d[i] = (i_sat_en && w_sum[SIZE]) ? '1 : w_sum[SIZE-1:0];
                            end
                            OP_SUB: begin
                                if (w_under) begin
                                    w_borrow_d[i] = 1'b1;
                                end
                                w_q_d[i] = (i_sat_en && w_under) ? '0 : w_diff;
                            end
                            OP_CLRFLAG: begin
                                w_carry_d[i]  = 1'b0;
                                w_borrow_d[i] = 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                case (i_cmd_op)
                    OP_CLRFLAG: begin
                        w_err_d = 1'b0;
                    end
                    OP_REPSUB: begin
                        w_rep_ch_d = i_cmd_ch;
                        w_step_d   = i_cmd_data;
                        w_quot_d   = '0;
                        if (i_cmd_data == '0) begin
                            // Division by zero: flag it and finish at once.
                            w_err_d   = 1'b1;
                            w_zdone_d = 1'b1;
                        end else begin
                            w_state_d = ST_REPEAT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            for (int i = 0; i < CH; i++) begin
                r_q[i] <= '0;
            end
            r_carry  <= '0;
            r_borrow <= '0;
            r_err    <= 1'b0;
            r_quot   <= '0;
            r_zdone  <= 1'b0;
            r_rep_ch <= '0;
            r_step   <= '0;
        end else begin
            r_state  <= w_state_d;
            for (int i = 0; i < CH; i++) begin
                r_q[i] <= w_q_d[i];
            end
            r_carry  <= w_carry_d;
            r_borrow <= w_borrow_d;
            r_err    <= w_err_d;
            r_quot   <= w_quot_d;
            r_zdone  <= w_zdone_d;
            r_rep_ch <= w_rep_ch_d;
            r_step   <= w_step_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            o_zero[i] = (r_q[i] == '0);
        end
    end

    // The final REPEAT cycle (remainder below step) is the done cycle, so
    // busy covers it and the FSM is back in IDLE on the following cycle.
    assign o_busy   = (r_state == ST_REPEAT);
    assign o_done   = r_zdone | ((r_state == ST_REPEAT) & ~w_rep_ge);
    assign o_carry  = r_carry;
    assign o_borrow = r_borrow;
    assign o_err    = r_err;
    assign o_quot   = r_quot;

endmodule

// File: tb/tb_arith_sfr.sv
// ---------------------------------------------------------------------------
// tb_arith_sfr: directed self-checking bench for arith_sfr (SIZE=8, CH=4).
// ---------------------------------------------------------------------------
module tb_arith_sfr;

    localparam int unsigned SIZE = 8;
    localparam int unsigned CH   = 4;
    localparam int unsigned CHW  = 2;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_CLRFLAG = 3'b100;
    localparam logic [2:0] OP_REPSUB  = 3'b101;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [CHW-1:0]  cmd_ch;
    logic [SIZE-1:0] cmd_data;
    logic            sat_en;
    logic [CHW-1:0]  rd_ch;
    logic [SIZE-1:0] rd_data;
    logic [CH-1:0]   zero;
    logic [CH-1:0]   carry;
    logic [CH-1:0]   borrow;
    logic            err;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quot;

    int n_checks = 0;
    int n_fail   = 0;

    arith_sfr #(
        .SIZE (SIZE),
        .CH   (CH),
        .CHW  (CHW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_ch    (cmd_ch),
        .i_cmd_data  (cmd_data),
        .i_sat_en    (sat_en),
        .i_rd_ch     (rd_ch),
        .o_rd_data   (rd_data),
        .o_zero      (zero),
        .o_carry     (carry),
        .o_borrow    (borrow),
        .o_err       (err),
        .o_busy      (busy),
        .o_done      (done),
        .o_quot      (quot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command at the falling edge, return 1 time unit after the
    // accepting rising edge with valid dropped.
    task automatic do_cmd(input logic [2:0] op, input logic [CHW-1:0] ch,
                          input logic [SIZE-1:0] data, input logic sat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_data  = data;
        sat_en    = sat;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        sat_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_ch    = '0;
        cmd_data  = '0;
        sat_en    = 1'b0;
        rd_ch     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low got %b exp 0", cmd_ready); end
        rst = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) begin
            rd_ch = CHW'(i);
            #1;
            n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL rst_q%0d got %0d exp 0", i, rd_data); end
        end
        n_checks++; if (zero !== 4'hF) begin n_fail++; $display("FAIL rst_zero got %b exp 1111", zero); end
        n_checks++; if ({carry, borrow} !== 8'h00) begin n_fail++; $display("FAIL rst_flags got %b exp 0", {carry, borrow}); end
        n_checks++; if ({err, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b exp 000", {err, busy, done}); end
        n_checks++; if (quot !== 8'd0) begin n_fail++; $display("FAIL rst_quot got %0d exp 0", quot); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    endtask

    // 200 / 7 = 28 rem 4, done on cycle 29 after accept.
    task automatic test_repsub();
        int done_cyc;
        int busy_cnt;
        logic rdy_seen;
        do_cmd(OP_LOAD, 2'd1, 8'd200, 1'b0);
        rd_ch = 2'd1;
        do_cmd(OP_REPSUB, 2'd1, 8'd7, 1'b0);
        done_cyc = 0;
        busy_cnt = 0;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 60 && done_cyc == 0; k++) begin
            if (busy) busy_cnt++;
            if (cmd_ready) rdy_seen = 1'b1;
            if (done) done_cyc = k;
            @(posedge clk);
            #1;
        end
        n_checks++; if (done_cyc != 29) begin n_fail++; $display("FAIL repsub_done_cycle got %0d exp 29", done_cyc); end
        n_checks++; if (busy_cnt != 29) begin n_fail++; $display("FAIL repsub_busy_cycles got %0d exp 29", busy_cnt); end
        n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL repsub_ready_low got %b exp 0", rdy_seen); end
        n_checks++; if (rd_data !== 8'd4) begin n_fail++; $display("FAIL repsub_rem got %0d exp 4", rd_data); end
        n_checks++; if (quot !== 8'd28) begin n_fail++; $display("FAIL repsub_quot got %0d exp 28", quot); end
        n_checks++; if ({busy, done, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL repsub_after got %b exp 001", {busy, done, cmd_ready}); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL repsub_err got %b exp 0", err); end
    endtask

    task automatic test_sub();
        rd_ch = 2'd0;
        do_cmd(OP_LOAD, 2'd0, 8'd30, 1'b0);
        do_cmd(OP_SUB, 2'd0, 8'd5, 1'b0);
        n_checks++; if (rd_data !== 8'd25) begin n_fail++; $display("FAIL sub_plain got %0d exp 25", rd_data); end
        n_checks++; if (borrow[0] !== 1'b0) begin n_fail++; $display("FAIL sub_plain_borrow got %b exp 0", borrow[0]); end
        do_cmd(OP_LOAD, 2'd0, 8'd10, 1'b0);
        do_cmd(OP_SUB, 2'd0, 8'd25, 1'b1);
        n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL sub_sat got %0d exp 0", rd_data); end
        n_checks++; if (borrow[0] !== 1'b1) begin n_fail++; $display("FAIL sub_sat_borrow got %b exp 1", borrow[0]); end
        n_checks++; if (zero[0] !== 1'b1) begin n_fail++; $display("FAIL sub_sat_zero got %b exp 1", zero[0]); end
        do_cmd(OP_LOAD, 2'd0, 8'd10, 1'b0);
        n_checks++; if (borrow[0] !== 1'b1) begin n_fail++; $display("FAIL load_keeps_borrow got %b exp 1", borrow[0]); end
        do_cmd(OP_SUB, 2'd0, 8'd25, 1'b0);
        n_checks++; if (rd_data !== 8'd241) begin n_fail++; $display("FAIL sub_wrap got %0d exp 241", rd_data); end
        n_checks++; if (borrow[0] !== 1'b1) begin n_fail++; $display("FAIL sub_wrap_borrow got %b exp 1", borrow[0]); end
        do_cmd(OP_CLRFLAG, 2'd0, 8'd0, 1'b0);
        n_checks++; if (borrow[0] !== 1'b0) begin n_fail++; $display("FAIL clrflag_borrow got %b exp 0", borrow[0]); end
        n_checks++; if (rd_data !== 8'd241) begin n_fail++; $display("FAIL clrflag_q got %0d exp 241", rd_data); end
    endtask

    task automatic test_add();
        rd_ch = 2'd2;
        do_cmd(OP_LOAD, 2'd2, 8'd250, 1'b0);
        do_cmd(OP_ADD, 2'd2, 8'd10, 1'b1);
        n_checks++; if (rd_data !== 8'd255) begin n_fail++; $display("FAIL add_sat got %0d exp 255", rd_data); end
        n_checks++; if (carry !== 4'b0100) begin n_fail++; $display("FAIL add_sat_carry got %b exp 0100", carry); end
        n_checks++; if (zero[2] !== 1'b0) begin n_fail++; $display("FAIL add_sat_zero got %b exp 0", zero[2]); end
        do_cmd(OP_LOAD, 2'd2, 8'd250, 1'b0);
        do_cmd(OP_ADD, 2'd2, 8'd10, 1'b0);
        n_checks++; if (rd_data !== 8'd4) begin n_fail++; $display("FAIL add_wrap got %0d exp 4", rd_data); end
        n_checks++; if (zero[2] !== 1'b0) begin n_fail++; $display("FAIL add_wrap_zero got %b exp 0", zero[2]); end
        do_cmd(OP_ADD, 2'd2, 8'd3, 1'b1);
        n_checks++; if (rd_data !== 8'd7) begin n_fail++; $display("FAIL add_plain got %0d exp 7", rd_data); end
        n_checks++; if (carry[2] !== 1'b1) begin n_fail++; $display("FAIL add_carry_sticky got %b exp 1", carry[2]); end
        do_cmd(OP_CLRFLAG, 2'd2, 8'd0, 1'b0);
        n_checks++; if (carry !== 4'b0000) begin n_fail++; $display("FAIL clrflag_carry got %b exp 0000", carry); end
    endtask

    // 50 / 5 aborted by reset in the 4th REPEAT cycle.
    task automatic test_rst_abort();
        logic done_seen;
        done_seen = 1'b0;
        rd_ch = 2'd3;
        do_cmd(OP_LOAD, 2'd3, 8'd50, 1'b0);
        do_cmd(OP_REPSUB, 2'd3, 8'd5, 1'b0);
        for (int k = 1; k < 4; k++) begin
            if (done) done_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++; if (quot !== 8'd3) begin n_fail++; $display("FAIL abort_quot_mid got %0d exp 3", quot); end
        n_checks++; if (rd_data !== 8'd35) begin n_fail++; $display("FAIL abort_q_mid got %0d exp 35", rd_data); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if ({busy, done, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL abort_ctl got %b exp 001", {busy, done, cmd_ready}); end
        n_checks++; if (quot !== 8'd0) begin n_fail++; $display("FAIL abort_quot got %0d exp 0", quot); end
        n_checks++; if (zero !== 4'hF) begin n_fail++; $display("FAIL abort_all_zero got %b exp 1111", zero); end
        for (int k = 0; k < 12; k++) begin
            if (done) done_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", done_seen); end
    endtask

    task automatic test_step_zero();
        int done_cyc;
        rd_ch = 2'd1;
        do_cmd(OP_LOAD, 2'd1, 8'd77, 1'b0);
        do_cmd(OP_REPSUB, 2'd1, 8'd10, 1'b0);
        done_cyc = 0;
        for (int k = 1; k <= 30 && done_cyc == 0; k++) begin
            if (done) done_cyc = k;
            @(posedge clk);
            #1;
        end
        n_checks++; if (done_cyc != 8) begin n_fail++; $display("FAIL div77_done_cycle got %0d exp 8", done_cyc); end
        n_checks++; if (quot !== 8'd7) begin n_fail++; $display("FAIL div77_quot got %0d exp 7", quot); end
        do_cmd(OP_REPSUB, 2'd1, 8'd0, 1'b0);
        n_checks++; if ({err, done, busy} !== 3'b110) begin n_fail++; $display("FAIL step0_ctl got %b exp 110", {err, done, busy}); end
        n_checks++; if (rd_data !== 8'd7) begin n_fail++; $display("FAIL step0_q got %0d exp 7", rd_data); end
        n_checks++; if (quot !== 8'd0) begin n_fail++; $display("FAIL step0_quot got %0d exp 0", quot); end
        @(posedge clk);
        #1;
        n_checks++; if ({done, err} !== 2'b01) begin n_fail++; $display("FAIL step0_pulse got %b exp 01", {done, err}); end
        do_cmd(OP_CLRFLAG, 2'd1, 8'd0, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clrflag_err got %b exp 0", err); end
        rd_ch = 2'd0;
        do_cmd(OP_LOAD, 2'd0, 8'd33, 1'b0);
        do_cmd(3'b110, 2'd0, 8'd5, 1'b1);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", err); end
        n_checks++; if (rd_data !== 8'd33) begin n_fail++; $display("FAIL illegal_q got %0d exp 33", rd_data); end
        n_checks++; if ({carry, borrow} !== 8'h00) begin n_fail++; $display("FAIL illegal_flags got %b exp 0", {carry, borrow}); end
    endtask

    // 20 / 6 = 3 rem 2 with a LOAD held pending behind it.
    task automatic test_back_to_back();
        int done_cyc;
        int acc_cyc;
        do_cmd(OP_LOAD, 2'd2, 8'd20, 1'b0);
        do_cmd(OP_REPSUB, 2'd2, 8'd6, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_ch    = 2'd0;
        cmd_data  = 8'd99;
        rd_ch     = 2'd1;
        done_cyc  = 0;
        acc_cyc   = 0;
        for (int k = 1; k <= 30 && acc_cyc == 0; k++) begin
            if (k == 2) begin
                n_checks++; if (rd_data !== 8'd7) begin n_fail++; $display("FAIL read_during_repeat got %0d exp 7", rd_data); end
            end
            if (done) done_cyc = k;
            if (cmd_ready) acc_cyc = k;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        n_checks++; if (done_cyc != 4) begin n_fail++; $display("FAIL b2b_done_cycle got %0d exp 4", done_cyc); end
        n_checks++; if (acc_cyc != 5) begin n_fail++; $display("FAIL b2b_accept_cycle got %0d exp 5", acc_cyc); end
        rd_ch = 2'd0;
        #1;
        n_checks++; if (rd_data !== 8'd99) begin n_fail++; $display("FAIL b2b_load got %0d exp 99", rd_data); end
        rd_ch = 2'd2;
        #1;
        n_checks++; if (rd_data !== 8'd2) begin n_fail++; $display("FAIL b2b_rem got %0d exp 2", rd_data); end
        n_checks++; if (quot !== 8'd3) begin n_fail++; $display("FAIL b2b_quot got %0d exp 3", quot); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_repsub();
        test_sub();
        test_add();
        test_rst_abort();
        test_step_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
